// File: rtl/md_unit_pkg.sv
// Shared op codes, op classes and result types for the multiply/divide unit.
package md_unit_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} op_t;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  function automatic logic is_arith(input logic [3:0] m);
    return (m == MD_MULT) || (m == MD_MULTU) || (m == MD_DIV) || (m == MD_DIVU);
  endfunction

  function automatic op_t op_of(input logic [3:0] m);
    case (m)
      MD_MULTU: return OP_MULTU;
      MD_DIV:   return OP_DIV;
      MD_DIVU:  return OP_DIVU;
      default:  return OP_MULT;
    endcase
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// EX-stage operand/mode bundle into the md unit and its read data / hazard outputs.
interface md_unit_if;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  mode;
  logic [31:0] out;
  logic        start;
  logic        busy;

  modport master (output a, b, mode, input out, start, busy);
  modport slave  (input a, b, mode, output out, start, busy);
endinterface

// File: rtl/md_unit_arith.sv
// Combinational multiply/divide datapath: 64-bit {hi,lo} result for one op class.
module md_arith
  import md_unit_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  op_t         op,
  output hilo_t       res,
  output logic        divzero
);

  logic signed [63:0] sa64, sb64, prod_s;
  logic        [63:0] prod_u;
  logic               sgn, neg_a, neg_b;
  logic        [31:0] mag_a, mag_b, dvs, q, r, quo, rem;

  assign sa64   = {{32{a[31]}}, a};
  assign sb64   = {{32{b[31]}}, b};
  assign prod_s = sa64 * sb64;
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow trap.
  assign sgn   = (op == OP_DIV);
  assign neg_a = sgn & a[31];
  assign neg_b = sgn & b[31];
  assign mag_a = neg_a ? (32'd0 - a) : a;
  assign mag_b = neg_b ? (32'd0 - b) : b;
  assign dvs   = (b == 32'd0) ? 32'd1 : mag_b;
  assign q     = mag_a / dvs;
  assign r     = mag_a % dvs;
  assign quo   = (neg_a ^ neg_b) ? (32'd0 - q) : q;
  assign rem   = neg_a ? (32'd0 - r) : r;

  assign divzero = ((op == OP_DIV) || (op == OP_DIVU)) && (b == 32'd0);

  always_comb begin
    res = '0;
    case (op)
      OP_MULT:  res = hilo_t'(prod_s);
      OP_MULTU: res = hilo_t'(prod_u);
      default:  begin res.hi = rem; res.lo = quo; end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle mul/div unit owning HI/LO; result commits MULT_LAT/DIV_LAT cycles after start.
// busy is registered; new arith ops and mthi/mtlo are ignored while busy.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
)(
  input  logic       clk,
  input  logic       reset,
  md_unit_if.slave   md
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  hilo_t             pend_q, pend_d;
  logic              dz_q, dz_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;

  op_t               op;
  hilo_t             res;
  logic              divzero;
  logic              start;

  assign op    = op_of(md.mode);
  assign start = is_arith(md.mode) && (state_q == ST_IDLE);

  md_arith u_arith (
    .a       (md.a),
    .b       (md.b),
    .op      (op),
    .res     (res),
    .divzero (divzero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = ((op == OP_DIV) || (op == OP_DIVU)) ? CNT_W'(DIV_LAT - 1)
                                                        : CNT_W'(MULT_LAT - 1);
          pend_d  = res;
          dz_d    = divzero;
        end else if (md.mode == MD_MTHI) begin
          hi_d = md.a;
        end else if (md.mode == MD_MTLO) begin
          lo_d = md.a;
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          // A zero divisor burns the full window but leaves HI/LO untouched.
          if (!dz_q) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    md.out = '0;
    if (md.mode == MD_MFHI)      md.out = hi_q;
    else if (md.mode == MD_MFLO) md.out = lo_q;
  end

  assign md.start = start;
  assign md.busy  = (state_q == ST_RUN);

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit with a cycle-level reference model and per-cycle output checks.
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int ML = 5;
  localparam int DL = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  md_unit_if tif ();

  md_unit #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (tif.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_viol = 0;

  // Model: architectural HI/LO plus one outstanding result that lands at cycle m_end.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          m_run = 1'b0, m_dz = 1'b0;
  int          cyc = 0, m_end = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compute(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output bit dz);
    int sa, sb;
    longint ps;
    logic [63:0] pu;
    sa = a; sb = b;
    hi = '0; lo = '0; dz = 1'b0;
    case (m)
      MD_MULT:  begin ps = longint'(sa) * longint'(sb); {hi, lo} = ps; end
      MD_MULTU: begin pu = {32'd0, a} * {32'd0, b}; {hi, lo} = pu; end
      MD_DIV: begin
        dz = (b == 0);
        if (!dz) begin
          if (a == 32'h80000000 && sb == -1) begin lo = 32'h80000000; hi = 0; end
          else begin lo = sa / sb; hi = sa % sb; end
        end
      end
      default: begin
        dz = (b == 0);
        if (!dz) begin lo = a / b; hi = a % b; end
      end
    endcase
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi = '0; m_lo = '0; m_run = 1'b0;
    end else begin
      if (m_run && (is_arith(tif.mode) || tif.mode == MD_MTHI || tif.mode == MD_MTLO)) begin
        n_viol++;
        $display("note: protocol violation, mode %0d presented while busy at cycle %0d", tif.mode, cyc);
      end
      if (m_run) begin
        if (cyc == m_end) begin
          m_run = 1'b0;
          if (!m_dz) begin m_hi = p_hi; m_lo = p_lo; end
        end
      end else if (is_arith(tif.mode)) begin
        compute(tif.mode, tif.a, tif.b, p_hi, p_lo, m_dz);
        m_run = 1'b1;
        m_end = cyc + ((tif.mode == MD_DIV || tif.mode == MD_DIVU) ? DL : ML);
      end else if (tif.mode == MD_MTHI) begin
        m_hi = tif.a;
      end else if (tif.mode == MD_MTLO) begin
        m_lo = tif.a;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_out;
    exp_out = (tif.mode == MD_MFHI) ? m_hi : (tif.mode == MD_MFLO) ? m_lo : 32'd0;
    chk("cyc_start", {31'd0, tif.start}, {31'd0, is_arith(tif.mode) && !m_run});
    chk("cyc_busy",  {31'd0, tif.busy},  {31'd0, m_run});
    chk("cyc_out",   tif.out, exp_out);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b);
    tif.mode = m; tif.a = a; tif.b = b;
  endtask

  // Returns at negedge+1 of the first cycle with busy low; n = busy cycles seen.
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!tif.busy) break;
      n++;
      @(posedge clk);
    end
    #1;
  endtask

  task automatic run_op(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input string name);
    int n;
    tick();
    drive(m, a, b);
    tick();
    drive(MD_NONE, 32'd0, 32'd0);
    wait_idle(n);
    chk({name, "_busy_cycles"}, n, lat);
  endtask

  task automatic read_hilo(input logic [31:0] hi, input logic [31:0] lo, input string name);
    chk({name, "_model_hi"}, m_hi, hi);
    chk({name, "_model_lo"}, m_lo, lo);
    drive(MD_MFHI, 32'd0, 32'd0); #1;
    chk({name, "_mfhi"}, tif.out, hi);
    drive(MD_MFLO, 32'd0, 32'd0); #1;
    chk({name, "_mflo"}, tif.out, lo);
    drive(MD_NONE, 32'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    drive(MD_NONE, 32'd0, 32'd0);
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_busy", {31'd0, tif.busy}, 32'd0);
    read_hilo(32'd0, 32'd0, "rst");
    reset = 1'b1;

    run_op(MD_MULT,  32'hFFFFFFFE, 32'd3, ML, "mult");
    read_hilo(32'hFFFFFFFF, 32'hFFFFFFFA, "mult");
    run_op(MD_MULTU, 32'hFFFFFFFE, 32'd3, ML, "multu");
    read_hilo(32'h00000002, 32'hFFFFFFFA, "multu");
    run_op(MD_DIV,   32'hFFFFFFF9, 32'd2, DL, "div");
    read_hilo(32'hFFFFFFFF, 32'hFFFFFFFD, "div");
    run_op(MD_DIVU,  32'd7, 32'd2, DL, "divu");
    read_hilo(32'd1, 32'd3, "divu");

    tick(); drive(MD_MTHI, 32'h12345678, 32'd0);
    tick(); drive(MD_MTLO, 32'h9ABCDEF0, 32'd0);
    tick(); drive(MD_NONE, 32'd0, 32'd0);
    run_op(MD_DIVU, 32'd5, 32'd0, DL, "divzero");
    read_hilo(32'h12345678, 32'h9ABCDEF0, "divzero");

    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, DL, "ovf");
    read_hilo(32'd0, 32'h80000000, "ovf");

    // Second mult presented the cycle busy drops; mtlo during its window must be ignored.
    tick(); drive(MD_MULT, 32'd7, 32'd6);
    tick(); drive(MD_NONE, 32'd0, 32'd0);
    wait_idle(n);
    chk("b2b_first_busy", n, ML);
    drive(MD_MULT, 32'd3, 32'd5); #1;
    chk("b2b_start", {31'd0, tif.start}, 32'd1);
    tick(); drive(MD_MTLO, 32'h0000DEAD, 32'd0);
    tick(); drive(MD_NONE, 32'd0, 32'd0);
    wait_idle(n);
    chk("b2b_second_busy", n, ML - 1);
    read_hilo(32'd0, 32'd15, "b2b");

    tick(); drive(MD_MULT, 32'd7, 32'd6);
    tick(); drive(MD_NONE, 32'd0, 32'd0);
    tick(); tick();
    #2 reset = 1'b0;
    #1 chk("rst_mid_busy", {31'd0, tif.busy}, 32'd0);
    tick(); reset = 1'b1;
    read_hilo(32'd0, 32'd0, "rst_mid");
    repeat (ML + 2) tick();
    chk("rst_mid_after_busy", {31'd0, tif.busy}, 32'd0);
    read_hilo(32'd0, 32'd0, "rst_mid_late");

    chk("protocol_violations", n_viol, 32'd1);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
